multicycle_control: RTL and testbench

// Main control FSM plus ALU decoder of the multicycle MIPS core. It drives the

---
 rtl/multicycle_control.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS main control FSM with ALU decoder
//
// Purpose: steps each instruction through fetch/decode/execute/memory/
// writeback, one state per clock, and drives the datapath selects/strobes.
// Ports:
//   clock, reset_n           rising-edge clock, synchronous active-low reset
//   op, funct, alu_Zero      instruction fields and ALU zero flag
//   alu_Control, alu_SrcA,   ALU operation and operand selects
//   alu_SrcB
//   pc_Src, pc_En            PC source select and load enable
//   iord, mem_Write          memory address select and write strobe
//   ir_Write, reg_Write,     IR load, register-file write controls
//   reg_Dst, mem_To_Reg
//   illegal_Instr            one-cycle pulse on undecodable op/funct
//   state                    current state (debug)
module multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               alu_Zero,
  output logic [2:0]         alu_Control,
  output logic               alu_SrcA,
  output logic [1:0]         alu_SrcB,
  output logic [1:0]         pc_Src,
  output logic               pc_En,
  output logic               iord,
  output logic               mem_Write,
  output logic               ir_Write,
  output logic               reg_Write,
  output logic               reg_Dst,
  output logic               mem_To_Reg,
  output logic               illegal_Instr,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     cur_state;
  state_t     nxt_state;
  logic [2:0] funct_ctrl;
  logic       funct_ok;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cur_state <= S_RST;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // R-type function decode; only consulted while in EXEC.
  always_comb begin
    funct_ctrl = ALU_ADD;
    funct_ok   = 1'b1;
    case (funct)
      6'b100000: funct_ctrl = ALU_ADD;
      6'b100010: funct_ctrl = ALU_SUB;
      6'b100100: funct_ctrl = ALU_AND;
      6'b100101: funct_ctrl = ALU_OR;
      6'b100110: funct_ctrl = ALU_XOR;
      6'b101010: funct_ctrl = ALU_SLT;
      default:   funct_ok   = 1'b0;
    endcase
  end

  always_comb begin
    nxt_state     = S_FETCH;
    alu_Control   = ALU_ADD;
    alu_SrcA      = 1'b0;
    alu_SrcB      = 2'b00;
    pc_Src        = 2'b00;
    pc_En         = 1'b0;
    iord          = 1'b0;
    mem_Write     = 1'b0;
    ir_Write      = 1'b0;
    reg_Write     = 1'b0;
    reg_Dst       = 1'b0;
    mem_To_Reg    = 1'b0;
    illegal_Instr = 1'b0;
    case (cur_state)
      S_RST: nxt_state = S_FETCH;
      S_FETCH: begin
        alu_SrcB  = 2'b01;
        ir_Write  = 1'b1;
        pc_En     = 1'b1;
        nxt_state = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes PC + (imm<<2) into ALUOut for a possible branch.
        alu_SrcB = 2'b11;
        case (op)
          OP_LW, OP_SW: nxt_state = S_MEMADR;
          OP_RTYPE:     nxt_state = S_EXEC;
          OP_BEQ:       nxt_state = S_BRANCH;
          OP_ADDI:      nxt_state = S_ADDIEX;
          OP_J:         nxt_state = S_JUMP;
          default: begin
            illegal_Instr = 1'b1;
            nxt_state     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_SrcA  = 1'b1;
        alu_SrcB  = 2'b10;
        nxt_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord      = 1'b1;
        nxt_state = S_MEMWB;
      end
      S_MEMWB: begin
        reg_Write  = 1'b1;
        mem_To_Reg = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_Write = 1'b1;
      end
      S_EXEC: begin
        alu_SrcA = 1'b1;
        if (funct_ok) begin
          alu_Control = funct_ctrl;
          nxt_state   = S_ALUWB;
        end else begin
          // Unknown funct: abort the instruction without a writeback.
          illegal_Instr = 1'b1;
          nxt_state     = S_FETCH;
        end
      end
      S_ALUWB: begin
        reg_Write = 1'b1;
        reg_Dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_SrcA    = 1'b1;
        alu_Control = ALU_SUB;
        pc_Src      = 2'b01;
        // Mealy term: taken branch loads PC straight from the zero flag.
        pc_En       = alu_Zero;
      end
      S_ADDIEX: begin
        alu_SrcA  = 1'b1;
        alu_SrcB  = 2'b10;
        nxt_state = S_ADDIWB;
      end
      S_ADDIWB: reg_Write = 1'b1;
      S_JUMP: begin
        pc_Src = 2'b10;
        pc_En  = 1'b1;
      end
      default: nxt_state = S_FETCH;
    endcase
  end

  assign state = STATE_W'(cur_state);

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       alu_Zero;
  logic [2:0] alu_Control;
  logic       alu_SrcA;
  logic [1:0] alu_SrcB;
  logic [1:0] pc_Src;
  logic       pc_En;
  logic       iord;
  logic       mem_Write;
  logic       ir_Write;
  logic       reg_Write;
  logic       reg_Dst;
  logic       mem_To_Reg;
  logic       illegal_Instr;
  logic [3:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_control #(.STATE_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .op(op), .funct(funct),
    .alu_Zero(alu_Zero), .alu_Control(alu_Control), .alu_SrcA(alu_SrcA),
    .alu_SrcB(alu_SrcB), .pc_Src(pc_Src), .pc_En(pc_En), .iord(iord),
    .mem_Write(mem_Write), .ir_Write(ir_Write), .reg_Write(reg_Write),
    .reg_Dst(reg_Dst), .mem_To_Reg(mem_To_Reg),
    .illegal_Instr(illegal_Instr), .state(dbg_state)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Instruction fields and ALU codes taken from the opcode/funct tables.
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;
  logic [5:0] funct_tab [6] = '{6'b100000, 6'b100010, 6'b100100,
                                6'b100101, 6'b100110, 6'b101010};
  logic [2:0] code_tab  [6] = '{3'b010, 3'b110, 3'b000,
                                3'b001, 3'b101, 3'b111};

  function automatic bit op_known(logic [5:0] o);
    return (o == LW) || (o == SW) || (o == RT) || (o == BEQ) ||
           (o == ADDI) || (o == J);
  endfunction

  function automatic int funct_idx(logic [5:0] f);
    for (int k = 0; k < 6; k++) if (funct_tab[k] == f) return k;
    return -1;
  endfunction

  // Expected {state, controls} for a given state number, from the per-state
  // output table.
  function automatic logic [19:0] model(int st, logic [5:0] o, logic [5:0] f,
                                        logic z);
    logic [2:0] ac;
    logic sa, pe, io, mw, iw, rw, rd, mr, il;
    logic [1:0] sb, ps;
    ac = 3'b010; sa = 0; sb = 0; ps = 0; pe = 0; io = 0; mw = 0;
    iw = 0; rw = 0; rd = 0; mr = 0; il = 0;
    case (st)
      1:  begin sb = 2'b01; iw = 1; pe = 1; end
      2:  begin sb = 2'b11; il = !op_known(o); end
      3, 10: begin sa = 1; sb = 2'b10; end
      4:  io = 1;
      5:  begin rw = 1; mr = 1; end
      6:  begin io = 1; mw = 1; end
      7:  begin
            sa = 1;
            if (funct_idx(f) >= 0) ac = code_tab[funct_idx(f)];
            else il = 1;
          end
      8:  begin rw = 1; rd = 1; end
      9:  begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; end
      11: rw = 1;
      12: begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    return {4'(st), ac, sa, sb, ps, pe, io, mw, iw, rw, rd, mr, il};
  endfunction

  function automatic logic [19:0] observed();
    return {dbg_state, alu_Control, alu_SrcA, alu_SrcB, pc_Src, pc_En, iord,
            mem_Write, ir_Write, reg_Write, reg_Dst, mem_To_Reg, illegal_Instr};
  endfunction

  task automatic check(string tag, logic [19:0] exp);
    logic [19:0] obs;
    obs = observed();
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one instruction from FETCH, checking every cycle; the DUT is
  // expected to be in FETCH at entry and back in FETCH afterwards.
  task automatic run_instr(string tag, logic [5:0] o, logic [5:0] f, bit rz,
                           logic zfix);
    int seq[$];
    seq = '{1, 2};
    if (o == LW)        seq = '{1, 2, 3, 4, 5};
    else if (o == SW)   seq = '{1, 2, 3, 6};
    else if (o == RT)   seq = (funct_idx(f) >= 0) ? '{1, 2, 7, 8} : '{1, 2, 7};
    else if (o == BEQ)  seq = '{1, 2, 9};
    else if (o == ADDI) seq = '{1, 2, 10, 11};
    else if (o == J)    seq = '{1, 2, 12};
    foreach (seq[i]) begin
      @(negedge clock);
      op = o;
      funct = f;
      alu_Zero = rz ? 1'($urandom_range(0, 1)) : zfix;
      #1;
      check(tag, model(seq[i], o, f, alu_Zero));
    end
  endtask

  initial begin
    logic [5:0] o, f;
    int pick;
    reset_n = 1'b0; op = '0; funct = '0; alu_Zero = 1'b0;

    // Reset held for two clocks, then released.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_hold", model(0, op, funct, 1'b0));
    reset_n = 1'b1;
    #1;
    check("reset_release", model(0, op, funct, 1'b0));

    // Directed instructions.
    run_instr("lw", LW, 6'h00, 0, 1'b0);
    run_instr("sw", SW, 6'h3f, 0, 1'b0);
    foreach (funct_tab[k]) run_instr("rtype", RT, funct_tab[k], 0, 1'b0);
    run_instr("beq_taken", BEQ, 6'h00, 0, 1'b1);
    run_instr("beq_not_taken", BEQ, 6'h00, 0, 1'b0);
    run_instr("addi", ADDI, 6'h00, 0, 1'b0);
    run_instr("jump", J, 6'h00, 0, 1'b0);
    run_instr("illegal_op", 6'b111111, 6'h00, 0, 1'b0);
    run_instr("illegal_funct", RT, 6'b000111, 0, 1'b0);

    // Reset in the middle of a store: the write strobe must drop at the edge.
    run_instr("sw_pre", LW, 6'h00, 0, 1'b0);
    @(negedge clock); op = SW; #1; check("sw_fetch", model(1, SW, 6'h0, 1'b0));
    @(negedge clock); #1; check("sw_decode", model(2, SW, 6'h0, 1'b0));
    @(negedge clock); #1; check("sw_memadr", model(3, SW, 6'h0, 1'b0));
    @(negedge clock); #1; check("sw_memwr", model(6, SW, 6'h0, 1'b0));
    reset_n = 1'b0;
    @(negedge clock); #1; check("sw_reset", model(0, SW, 6'h0, 1'b0));
    reset_n = 1'b1;
    @(negedge clock); #1; check("sw_refetch", model(1, SW, 6'h0, 1'b0));
    // Finish this FETCH so the random phase starts from a fresh FETCH.
    @(negedge clock); #1; check("sw_redecode", model(2, SW, 6'h0, 1'b0));
    @(negedge clock); #1; check("sw_readr", model(3, SW, 6'h0, 1'b0));
    @(negedge clock); #1; check("sw_rewr", model(6, SW, 6'h0, 1'b0));

    // Randomized instruction stream.
    for (int n = 0; n < 200; n++) begin
      pick = $urandom_range(0, 6);
      f = 6'($urandom_range(0, 63));
      case (pick)
        0: o = LW;
        1: o = SW;
        2: begin
             o = RT;
             if ($urandom_range(0, 3) != 0) f = funct_tab[$urandom_range(0, 5)];
           end
        3: o = BEQ;
        4: o = ADDI;
        5: o = J;
        default: begin
          o = 6'($urandom_range(0, 63));
          while (op_known(o)) o = 6'($urandom_range(0, 63));
        end
      endcase
      run_instr("random", o, f, 1, 1'b0);
    end
    @(negedge clock); #1;
    check("final_fetch", model(1, op, funct, alu_Zero));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
